// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the ID-stage hazard/stall controller.
// Register-zero constant, stall-need and FSM state encodings, source-match helper.
package hazard_stall_unit_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      NEED_NONE = 2'd0,
      NEED_ONE  = 2'd1,
      NEED_TWO  = 2'd2
   } need_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // True when producer register x feeds a source operand of the ID instruction.
   function automatic logic src_hit(input logic [4:0] x, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic rt_used);
      return (x != REG_ZERO) && ((x == rs) || ((x == rt) && rt_used));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             Clk_i,
   input  logic             Reset_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {WIDTH{1'b1}}))
         count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge Clk_i) begin
      if (Reset_i) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use and ID-branch operand stalls, taken-branch
// IF/ID squash, and saturating stall/flush event counters.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 Clk_i,
   input  logic                 Reset_i,
   input  logic [4:0]           IDrs_i,
   input  logic [4:0]           IDrt_i,
   input  logic                 IDimmBit_i,
   input  logic                 IDMemWrite_i,
   input  logic                 IDBranch_i,
   input  logic                 IDBranchTaken_i,
   input  logic                 EXMemRead_i,
   input  logic                 EXRegWrite_i,
   input  logic [4:0]           EXrd_i,
   input  logic                 MemMemRead_i,
   input  logic                 MemRegWrite_i,
   input  logic [4:0]           Memrd_i,
   output logic                 PCWrite_o,
   output logic                 IFIDWrite_o,
   output logic                 IFIDFlush_o,
   output logic                 IDEXFlush_o,
   output logic [CNT_WIDTH-1:0] StallCycles_o,
   output logic [CNT_WIDTH-1:0] BranchFlushes_o
);

   state_e state_q, state_d;
   logic   cnt_q, cnt_d;
   need_e  need;
   logic   rt_used, ex_hit, mem_hit, stall;

   // A load sitting in Mem also asserts MemRegWrite, so its load flag adds nothing.
   logic unused_mem_read;
   assign unused_mem_read = MemMemRead_i;

   assign rt_used = ~IDimmBit_i | IDMemWrite_i | IDBranch_i;
   assign ex_hit  = src_hit(EXrd_i, IDrs_i, IDrt_i, rt_used);
   assign mem_hit = src_hit(Memrd_i, IDrs_i, IDrt_i, rt_used);

   always_comb begin
      need = NEED_NONE;
      if ((IDBranch_i & MemRegWrite_i & mem_hit) | (~IDBranch_i & EXMemRead_i & ex_hit))
         need = NEED_ONE;
      if (IDBranch_i & EXRegWrite_i & ex_hit)
         need = NEED_TWO;
   end

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         state_q <= ST_RUN;
         cnt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // HOLD stalls blindly; the producer is known to reach WB by the time it ends.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (need == NEED_TWO) begin
               state_d = ST_HOLD;
               cnt_d   = 1'b1;
            end
         end
         ST_HOLD: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == 1'b0) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      stall       = (state_q == ST_HOLD) | (need != NEED_NONE);
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      IDEXFlush_o = 1'b0;
      IFIDFlush_o = 1'b0;
      if (Reset_i) begin
         IDEXFlush_o = 1'b1;
      end else if (stall) begin
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
         IDEXFlush_o = 1'b1;
      end else begin
         IFIDFlush_o = IDBranch_i & IDBranchTaken_i;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .Clk_i   (Clk_i),
      .Reset_i (Reset_i),
      .inc_i   (stall & ~Reset_i),
      .count_o (StallCycles_o)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .Clk_i   (Clk_i),
      .Reset_i (Reset_i),
      .inc_i   (IFIDFlush_o),
      .count_o (BranchFlushes_o)
   );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed hazard cases then random traffic,
// checked against a cycle-level model of the stall/flush rules.
module tb_hazard_stall_unit;

   localparam int CW   = 3;
   localparam int MAXC = (1 << CW) - 1;

   typedef struct packed {
      bit       rst;
      bit [4:0] rs, rt;
      bit       imm, mw, br, bt, exmr, exrw;
      bit [4:0] exrd;
      bit       memmr, memrw;
      bit [4:0] memrd;
   } stim_t;

   typedef struct packed {
      logic          pcw, ifidw, ifidf, idexf;
      logic [CW-1:0] sc, bf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    rs, rt, exrd, memrd;
   logic          imm, mw, br, bt, exmr, exrw, memmr, memrw;
   logic          pcw, ifidw, ifidf, idexf;
   logic [CW-1:0] sc, bf;

   exp_t  sb[$];
   int    total = 0, passed = 0, nfail = 0;
   int    m_hold = 0, m_sc = 0, m_bf = 0;
   stim_t cur;

   always #5 clk = ~clk;

   hazard_stall_unit #(.CNT_WIDTH(CW)) dut (
      .Clk_i(clk), .Reset_i(rst), .IDrs_i(rs), .IDrt_i(rt), .IDimmBit_i(imm),
      .IDMemWrite_i(mw), .IDBranch_i(br), .IDBranchTaken_i(bt),
      .EXMemRead_i(exmr), .EXRegWrite_i(exrw), .EXrd_i(exrd),
      .MemMemRead_i(memmr), .MemRegWrite_i(memrw), .Memrd_i(memrd),
      .PCWrite_o(pcw), .IFIDWrite_o(ifidw), .IFIDFlush_o(ifidf), .IDEXFlush_o(idexf),
      .StallCycles_o(sc), .BranchFlushes_o(bf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else begin
         nfail++;
         if (nfail <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: the DUT presents a full output set every cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("PCWrite", 32'(pcw), 32'(e.pcw));
         chk("IFIDWrite", 32'(ifidw), 32'(e.ifidw));
         chk("IFIDFlush", 32'(ifidf), 32'(e.ifidf));
         chk("IDEXFlush", 32'(idexf), 32'(e.idexf));
         chk("StallCycles", 32'(sc), 32'(e.sc));
         chk("BranchFlushes", 32'(bf), 32'(e.bf));
      end
   end

   task automatic apply(input stim_t s);
      rst = s.rst; rs = s.rs; rt = s.rt; imm = s.imm; mw = s.mw; br = s.br; bt = s.bt;
      exmr = s.exmr; exrw = s.exrw; exrd = s.exrd;
      memmr = s.memmr; memrw = s.memrw; memrd = s.memrd;
   endtask

   function automatic bit hit(input bit [4:0] x, input stim_t s);
      bit rt_src;
      rt_src = !s.imm || s.mw || s.br;
      return (x != 0) && ((x == s.rs) || ((x == s.rt) && rt_src));
   endfunction

   // One pipeline cycle: drive inputs, predict this cycle's outputs, advance the model.
   task automatic step(input stim_t s);
      exp_t e;
      bit   st, need1, need2;
      @(posedge clk); #1;
      apply(s);
      e.sc = m_sc[CW-1:0];
      e.bf = m_bf[CW-1:0];
      if (s.rst) begin
         e.pcw = 1; e.ifidw = 1; e.idexf = 1; e.ifidf = 0;
         m_hold = 0; m_sc = 0; m_bf = 0;
      end else begin
         need2 = s.br && s.exrw && hit(s.exrd, s);
         need1 = (s.br && s.memrw && hit(s.memrd, s)) || (!s.br && s.exmr && hit(s.exrd, s));
         if (m_hold > 0) begin
            st = 1; m_hold--;
         end else begin
            st = need1 || need2;
            if (need2) m_hold = 1;  // branch on an EX producer: 2 stall cycles in total
         end
         e.pcw = !st; e.ifidw = !st; e.idexf = st;
         e.ifidf = !st && s.br && s.bt;
         if (st && m_sc < MAXC) m_sc++;
         if (e.ifidf && m_bf < MAXC) m_bf++;
      end
      sb.push_back(e);
   endtask

   initial begin
      cur = '0; cur.rst = 1;
      apply(cur);
      @(posedge clk);
      step(cur);                               // reset-state outputs and cleared counters
      cur.rst = 0;
      step(cur);

      // load-use, then producer advanced to Mem
      cur.exmr = 1; cur.exrw = 1; cur.exrd = 8; cur.rs = 8;
      step(cur);
      cur.exmr = 0; cur.exrw = 0; cur.memmr = 1; cur.memrw = 1; cur.memrd = 8;
      step(cur);
      cur = '0; step(cur);

      // immediate: rt only a source for stores
      cur.exmr = 1; cur.exrd = 9; cur.rt = 9; cur.imm = 1;
      step(cur);
      cur.mw = 1; step(cur);
      cur = '0; step(cur);

      // branch on EX ALU result, EX changes during HOLD, then taken
      cur.br = 1; cur.exrw = 1; cur.exrd = 5; cur.rs = 5;
      step(cur);
      cur.exrw = 0; cur.exrd = 7;
      step(cur);
      cur.bt = 1; step(cur);
      cur = '0; step(cur);

      // branch on Mem result, then register zero
      cur.br = 1; cur.memrw = 1; cur.memrd = 5; cur.rt = 5;
      step(cur);
      cur.memrd = 0; cur.rt = 0; step(cur);
      cur = '0; step(cur);

      // reset in the middle of HOLD
      cur.br = 1; cur.exrw = 1; cur.exrd = 5; cur.rs = 5;
      step(cur);
      cur = '0; cur.rst = 1; step(cur);
      cur.rst = 0; step(cur);

      // saturation of the stall counter
      cur.exmr = 1; cur.exrd = 3; cur.rs = 3;
      repeat (10) step(cur);
      cur = '0; step(cur);

      repeat (2000) begin
         cur.rst   = ($urandom_range(0, 39) == 0);
         cur.rs    = 5'($urandom_range(0, 3));
         cur.rt    = 5'($urandom_range(0, 3));
         cur.exrd  = 5'($urandom_range(0, 3));
         cur.memrd = 5'($urandom_range(0, 3));
         cur.imm   = 1'($urandom); cur.mw   = 1'($urandom);
         cur.br    = 1'($urandom); cur.bt   = 1'($urandom);
         cur.exmr  = 1'($urandom); cur.exrw = 1'($urandom);
         cur.memmr = 1'($urandom); cur.memrw = 1'($urandom);
         step(cur);
      end

      @(negedge clk); #1;
      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
